// File: rtl/serial_subtractor_nbit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_nbit
//   Bit-serial unsigned subtractor. One start request latches a, b and
//   borrow_in, then the difference is formed one bit per clock, LSB first.
//   When all NUM_BITS bits are processed, the block updates diff/underflow
//   and pulses done for one cycle. A start in the DONE cycle launches the
//   next subtraction immediately.
//
// Ports
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   start      request to begin one subtraction (ignored while busy)
//   a, b       unsigned minuend / subtrahend, NUM_BITS wide
//   borrow_in  incoming borrow
//   busy       1 while bits are being shifted through
//   done       one-cycle pulse: diff/underflow hold a new result
//   diff       registered (a - b - borrow_in) mod 2^NUM_BITS
//   underflow  registered final borrow (a < b + borrow_in)
// -----------------------------------------------------------------------------
module serial_subtractor_nbit #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                underflow
);

  localparam int CW = $clog2(NUM_BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_BITS-1:0] a_q, a_d;
  logic [NUM_BITS-1:0] b_q, b_d;
  logic                br_q, br_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NUM_BITS-1:0] diff_q, diff_d;
  logic                uf_q, uf_d;

  // One full-subtractor slice on the current LSBs of the operand registers.
  logic ai, bi, d_bit, br_nxt;
  assign ai     = a_q[0];
  assign bi     = b_q[0];
  assign d_bit  = ai ^ bi ^ br_q;
  assign br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);

  logic last_bit;
  assign last_bit = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SHIFT: if (last_bit) state_d = S_DONE;
      // IDLE, DONE and any illegal encoding: start launches, else idle.
      default: state_d = start ? S_SHIFT : S_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    br_d   = br_q;
    diff_d = diff_q;
    uf_d   = uf_q;
    case (state_q)
      S_SHIFT: begin
        // a_q doubles as the result shift register: each difference bit
        // enters at the MSB as the consumed minuend bit leaves at the LSB.
        a_d  = {d_bit, a_q[NUM_BITS-1:1]};
        b_d  = {1'b0, b_q[NUM_BITS-1:1]};
        br_d = br_nxt;
        if (last_bit) begin
          diff_d = {d_bit, a_q[NUM_BITS-1:1]};
          uf_d   = br_nxt;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          br_d  = borrow_in;
          cnt_d = '0;
        end
      end
    endcase
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      uf_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      br_q   <= br_d;
      busy_q <= busy_d;
      done_q <= done_d;
      diff_q <= diff_d;
      uf_q   <= uf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign diff      = diff_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
module tb_serial_subtractor_nbit;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic [3:0] a, b;
  logic       borrow_in;
  logic       busy, done, underflow;
  logic [3:0] diff;

  int total = 0;
  int bad   = 0;

  serial_subtractor_nbit #(.NUM_BITS(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .a(a), .b(b),
    .borrow_in(borrow_in), .busy(busy), .done(done), .diff(diff),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       uf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One isolated operation from IDLE, checking the full busy/done timeline.
  task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                        input logic [3:0] ed, input logic eu, input string nm);
    @(negedge clk);
    start = 1'b1; a = va; b = vb; borrow_in = vbin;
    @(negedge clk);                         // E0 has sampled start
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({nm, "_busy"}, {30'd0, busy, done}, 32'd2);
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);                         // after E4: DONE
    check({nm, "_done"}, {30'd0, busy, done}, 32'd1);
    check({nm, "_res"}, {27'd0, underflow, diff}, {27'd0, eu, ed});
    @(negedge clk);
    check({nm, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  vec_t vecs[9];
  vec_t b2b[3];
  int   ndone;
  logic [4:0] model;

  initial begin
    vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
    vecs[1] = '{4'd3,  4'd9,  1'b0, 4'd10, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
    vecs[4] = '{4'd7,  4'd2,  1'b1, 4'd4,  1'b0};
    vecs[5] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1};
    vecs[6] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};
    vecs[7] = '{4'd8,  4'd7,  1'b1, 4'd0,  1'b0};
    vecs[8] = '{4'd5,  4'd10, 1'b0, 4'd11, 1'b1};
    b2b[0]  = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
    b2b[1]  = '{4'd2,  4'd5,  1'b1, 4'd12, 1'b1};
    b2b[2]  = '{4'd14, 4'd6,  1'b1, 4'd7,  1'b0};

    start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    check("reset_async", {25'd0, busy, done, underflow, diff}, 32'd0);
    repeat (2) @(negedge clk);
    check("reset_hold", {25'd0, busy, done, underflow, diff}, 32'd0);
    n_rst = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].uf, $sformatf("vec%0d", i));

    // Start pulsed mid-operation with new operands: must be ignored.
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd3; borrow_in = 1'b0;
    @(negedge clk); start = 1'b0;                              // after E0
    @(negedge clk); start = 1'b1; a = 4'd1; b = 4'd2; borrow_in = 1'b1; // after E1
    @(negedge clk); start = 1'b0;                              // after E2
    @(negedge clk);                                            // after E3
    check("ign_busy", {30'd0, busy, done}, 32'd2);
    @(negedge clk);                                            // after E4
    check("ign_done", {30'd0, busy, done}, 32'd1);
    check("ign_res", {27'd0, underflow, diff}, {27'd0, 1'b0, 4'd6});
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_extra_done", ndone, 0);
    check("ign_idle_busy", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; a = b2b[0].a; b = b2b[0].b; borrow_in = b2b[0].bin;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k % 5 == 0) begin
        check($sformatf("b2b_done%0d", k), {30'd0, busy, done}, 32'd1);
        check($sformatf("b2b_res%0d", k), {27'd0, underflow, diff},
              {27'd0, b2b[k/5-1].uf, b2b[k/5-1].d});
        if (k / 5 < 3) begin
          a = b2b[k/5].a; b = b2b[k/5].b; borrow_in = b2b[k/5].bin;
        end else begin
          start = 1'b0;
        end
      end else begin
        check($sformatf("b2b_busy%0d", k), {30'd0, busy, done}, 32'd2);
      end
    end
    @(negedge clk);
    check("b2b_end", {30'd0, busy, done}, 32'd0);

    // Reset during SHIFT: abort, outputs clear at once, no done afterwards.
    @(negedge clk);
    start = 1'b1; a = 4'd12; b = 4'd3; borrow_in = 1'b0;
    @(negedge clk); start = 1'b0;   // after E0
    @(negedge clk);                 // after E1
    @(negedge clk);                 // after E2
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    n_rst = 1'b0;
    #1;
    check("abort_async", {25'd0, busy, done, underflow, diff}, 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort_quiet", ndone, 0);
    run_op(4'd7, 4'd2, 1'b1, 4'd4, 1'b0, "after_abort");

    // Exhaustive sweep against an arithmetic model.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] sa, sb;
      logic       sbin;
      sa   = i[8:5];
      sb   = i[4:1];
      sbin = i[0];
      model = {1'b0, sa} - {1'b0, sb} - {4'd0, sbin};
      run_op(sa, sb, sbin, model[3:0], model[4], $sformatf("sw_%0d_%0d_%0d", sa, sb, sbin));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
